// File: rtl/data_mem_be.sv
// Word-organised data memory with byte-lane stores, sign/zero-extending loads,
// alignment checking and an optional zero-fill sequence after reset.
module data_mem_be #(
   parameter int ADDR_W         = 10,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              unsigned_ld,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              rvalid,
   output logic [31:0]       rdata,
   output logic              err
);

   localparam int          IDX_W = ADDR_W - 2;
   localparam int unsigned DEPTH = 2 ** IDX_W;

   typedef enum logic {
      S_INIT,
      S_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             rvalid_q, rvalid_d;
   logic             err_q, err_d;
   logic [31:0]      rdata_q, rdata_d;

   logic [31:0]      mem_q [DEPTH];

   logic             accept;
   logic             illegal;
   logic [IDX_W-1:0] idx;
   logic [31:0]      rd_word;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      ld_data;
   logic [3:0]       wr_be;
   logic [IDX_W-1:0] wr_idx;
   logic [31:0]      wr_data;

   // Gated by rst directly so that, without the fill, ready rises in the very
   // first cycle after reset release yet stays low while reset is held.
   assign ready  = (state_q == S_IDLE) && !rst;
   assign accept = req && ready;
   assign idx    = addr[ADDR_W-1:2];
   assign rd_word = mem_q[idx];

   assign rvalid = rvalid_q;
   assign err    = err_q;
   assign rdata  = rdata_q;

   always_comb begin
      unique case (size)
         2'b00:   illegal = 1'b0;
         2'b01:   illegal = addr[0];
         2'b10:   illegal = (addr[1:0] != 2'b00);
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      byte_sel = rd_word[{addr[1:0], 3'b000} +: 8];
      half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];
      unique case (size)
         2'b00:   ld_data = unsigned_ld ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   ld_data = unsigned_ld ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ld_data = rd_word;
      endcase
   end

   always_comb begin
      wr_be   = '0;
      wr_idx  = idx;
      wr_data = wdata;
      if (!rst) begin
         if (state_q == S_INIT) begin
            wr_be   = '1;
            wr_idx  = cnt_q;
            wr_data = '0;
         end else if (accept && we && !illegal) begin
            unique case (size)
               2'b00: begin
                  wr_be   = 4'b0001 << addr[1:0];
                  wr_data = {4{wdata[7:0]}};
               end
               2'b01: begin
                  wr_be   = addr[1] ? 4'b1100 : 4'b0011;
                  wr_data = {2{wdata[15:0]}};
               end
               default: wr_be = '1;
            endcase
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      if (state_q == S_INIT) begin
         if (cnt_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
         else                            cnt_d   = cnt_q + 1'b1;
      end
      if (accept) begin
         err_d    = illegal;
         rvalid_d = !illegal && !we;
         if (!illegal && !we) rdata_d = ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // Storage is never reset; the INIT sequence is the only clearing path.
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < 4; b++) begin
         if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_data_mem_be.sv
// Directed bench for data_mem_be: reset fill timing, lane stores, load
// extension, alignment rejects, back-to-back hazards and reset mid-fill.
module tb_data_mem_be;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic              unsigned_ld;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              ready;
   logic              rvalid;
   logic [31:0]       rdata;
   logic              err;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   data_mem_be #(
      .ADDR_W         (ADDR_W),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .we          (we),
      .size        (size),
      .unsigned_ld (unsigned_ld),
      .addr        (addr),
      .wdata       (wdata),
      .ready       (ready),
      .rvalid      (rvalid),
      .rdata       (rdata),
      .err         (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   // Presents one request for a single cycle; returns at the negedge after the
   // accepting edge, where the response is visible.
   task automatic access(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = w; size = sz; unsigned_ld = uns; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                       input logic [ADDR_W-1:0] a, input logic [31:0] exp);
      access(1'b0, sz, uns, a, 32'h0);
      check({tag, ".rvalid"}, {31'h0, rvalid}, 32'h1);
      check({tag, ".err"}, {31'h0, err}, 32'h0);
      check(tag, rdata, exp);
   endtask

   task automatic store(input string tag, input logic [1:0] sz,
                        input logic [ADDR_W-1:0] a, input logic [31:0] d);
      access(1'b1, sz, 1'b0, a, d);
      check({tag, ".rvalid"}, {31'h0, rvalid}, 32'h0);
      check({tag, ".err"}, {31'h0, err}, 32'h0);
   endtask

   task automatic reject(input string tag, input logic w, input logic [1:0] sz,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input logic [31:0] prev);
      access(w, sz, 1'b0, a, d);
      check({tag, ".err"}, {31'h0, err}, 32'h1);
      check({tag, ".rvalid"}, {31'h0, rvalid}, 32'h0);
      check({tag, ".rdata"}, rdata, prev);
      @(negedge clk);
      check({tag, ".err_pulse"}, {31'h0, err}, 32'h0);
   endtask

   task automatic wait_ready(output int n, output logic stray);
      n = 0;
      stray = 1'b0;
      while (ready !== 1'b1 && n < 1000) begin
         stray = stray | rvalid | err;
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int   n;
      logic stray;

      rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
      addr = '0; wdata = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst.ready",  {31'h0, ready},  32'h0);
      check("rst.rvalid", {31'h0, rvalid}, 32'h0);
      check("rst.err",    {31'h0, err},    32'h0);
      check("rst.rdata",  rdata,           32'h0);

      // A store held throughout the fill must never be taken.
      rst = 1'b0;
      req = 1'b1; we = 1'b1; size = 2'b10; addr = 10'h040; wdata = 32'h0000_0055;
      wait_ready(n, stray);
      req = 1'b0;
      check("fill.cycles", n, 256);
      check("fill.stray",  {31'h0, stray}, 32'h0);
      check("fill.ready",  {31'h0, ready}, 32'h1);

      load("lw_0x40", 2'b10, 1'b0, 10'h040, 32'h0000_0000);
      @(negedge clk);
      check("lw_0x40.pulse", {31'h0, rvalid}, 32'h0);

      store("sw_0x4", 2'b10, 10'h004, 32'h8000_00F3);
      check("sw_0x4.hold", rdata, 32'h0000_0000);
      load("lb_0x4",  2'b00, 1'b0, 10'h004, 32'hFFFF_FFF3);
      load("lbu_0x4", 2'b00, 1'b1, 10'h004, 32'h0000_00F3);
      load("lh_0x6",  2'b01, 1'b0, 10'h006, 32'hFFFF_8000);
      load("lhu_0x6", 2'b01, 1'b1, 10'h006, 32'h0000_8000);
      load("lwu_0x4", 2'b10, 1'b1, 10'h004, 32'h8000_00F3);

      store("sw_0x8", 2'b10, 10'h008, 32'h1122_3344);
      store("sb_0x9", 2'b00, 10'h009, 32'h0000_00AB);
      store("sh_0xA", 2'b01, 10'h00A, 32'h0000_CAFE);
      load("lw_0x8",  2'b10, 1'b0, 10'h008, 32'hCAFE_AB44);
      load("lb_0x9",  2'b00, 1'b0, 10'h009, 32'hFFFF_FFAB);
      load("lbu_0xB", 2'b00, 1'b1, 10'h00B, 32'h0000_00CA);
      load("lh_0x8",  2'b01, 1'b0, 10'h008, 32'hFFFF_AB44);

      reject("lw_0x6",   1'b0, 2'b10, 10'h006, 32'h0,           32'h0000_00CA - 32'h0000_00CA + 32'hFFFF_AB44);
      reject("sw_0x2",   1'b1, 2'b10, 10'h002, 32'hDEAD_BEEF,   32'hFFFF_AB44);
      reject("lh_0x5",   1'b0, 2'b01, 10'h005, 32'h0,           32'hFFFF_AB44);
      reject("size11",   1'b0, 2'b11, 10'h008, 32'h0,           32'hFFFF_AB44);
      reject("sh_0x9",   1'b1, 2'b01, 10'h009, 32'h0000_BEEF,   32'hFFFF_AB44);
      load("lw_0x0", 2'b10, 1'b0, 10'h000, 32'h0000_0000);
      load("lw_0x8b", 2'b10, 1'b0, 10'h008, 32'hCAFE_AB44);

      // Store followed immediately by a load to the same word.
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b10; unsigned_ld = 1'b0; addr = 10'h010; wdata = 32'h1234_5678;
      @(negedge clk);
      check("b2b.st_rvalid", {31'h0, rvalid}, 32'h0);
      we = 1'b0;
      @(negedge clk);
      req = 1'b0;
      check("b2b.ld_rvalid", {31'h0, rvalid}, 32'h1);
      check("b2b.ld_rdata",  rdata, 32'h1234_5678);

      store("sw_top", 2'b10, 10'h3FC, 32'hA5A5_5A5A);
      load("lw_top",   2'b10, 1'b0, 10'h3FC, 32'hA5A5_5A5A);
      load("lw_0x0b",  2'b10, 1'b0, 10'h000, 32'h0000_0000);

      // Load presented in the same cycle as reset: must not produce rvalid.
      @(negedge clk);
      req = 1'b1; we = 1'b0; size = 2'b10; addr = 10'h008; rst = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("rst_ld.rvalid", {31'h0, rvalid}, 32'h0);
      check("rst_ld.rdata",  rdata,           32'h0);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("midfill.ready", {31'h0, ready}, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_ready(n, stray);
      check("refill.cycles", n, 256);
      check("refill.stray",  {31'h0, stray}, 32'h0);
      load("lw_0x8_clr", 2'b10, 1'b0, 10'h008, 32'h0000_0000);
      load("lw_top_clr", 2'b10, 1'b0, 10'h3FC, 32'h0000_0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
